// File: rtl/uart_rx_cfg_if.sv
// Output handshake bundle of the configurable UART receiver.
// The receiver drives the master side and the word consumer drives the slave side.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 ready_i;
    logic                 valid_o;
    logic [DATA_BITS-1:0] data_o;
    logic                 parity_err_o;
    logic                 frame_err_o;
    logic                 overrun_o;

    modport master (
        input  ready_i,
        output valid_o, data_o, parity_err_o, frame_err_o, overrun_o
    );

    modport slave (
        output ready_i,
        input  valid_o, data_o, parity_err_o, frame_err_o, overrun_o
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, parity, stop bits, valid/ready output with overrun.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around mid-bit.
module uart_rx_cfg #(
    parameter int CLK_DIV_FACTOR = 10416,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          rx_i,
    output logic          busy_o,
    uart_rx_cfg_if.master rx_if
);
    localparam int              CW         = $clog2(CLK_DIV_FACTOR);
    localparam logic [CW-1:0]   LAST_CNT_C = CW'(CLK_DIV_FACTOR - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0]   SAMPLE_C   = CW'(CLK_DIV_FACTOR / 2 + 1);
`else
    localparam logic [CW-1:0]   SAMPLE_C   = CW'(CLK_DIV_FACTOR / 2);
`endif
    localparam logic [3:0]      LAST_BIT_C  = 4'(DATA_BITS - 1);
    localparam logic [3:0]      LAST_STOP_C = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Odd mode expects XOR(data) = ~sample, even mode expects XOR(data) = sample.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data, input logic sample);
        logic x;
        x = (^data) ^ sample;
        if (PARITY_MODE == 1) begin
            return ~x;
        end else begin
            return x;
        end
    endfunction

    logic                 rx_meta_q, rx_sync_q;
    logic                 bit_val_s;
    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_next_s;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d, frm_err_q, frm_err_d;
    logic                 done_s, consume_s, at_sample_s, at_end_s;
    logic                 valid_q, valid_d, perr_out_q, perr_out_d, ferr_out_q, ferr_out_d;
    logic                 ovr_q, ovr_d, busy_q, busy_d;
    logic [DATA_BITS-1:0] data_q, data_d;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Holds rx_sync at the two preceding counts, so at MID+1 it covers MID-1 and MID.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_sync_q};
        end
    end

    assign bit_val_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_sync_q) | (hist_q[0] & rx_sync_q);
`else
    assign bit_val_s = rx_sync_q;
`endif

    // Frame FSM next state plus output register next values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        frm_err_d   = frm_err_q;
        done_s      = 1'b0;
        at_sample_s = (cnt_q == SAMPLE_C);
        at_end_s    = (cnt_q == LAST_CNT_C);
        cnt_next_s  = at_end_s ? '0 : cnt_q + CW'(1);

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = 4'd0;
                if (!rx_sync_q) begin
                    state_d   = ST_START;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                cnt_d = cnt_next_s;
                if (at_sample_s && bit_val_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (at_end_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_next_s;
                if (at_sample_s) begin
                    shift_d = {bit_val_s, shift_q[DATA_BITS-1:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (at_end_s && (bit_idx_q == LAST_BIT_C)) begin
                    bit_idx_d = 4'd0;
                    state_d   = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                end else if (at_end_s) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                end else begin
                    bit_idx_d = bit_idx_q;
                end
            end
            ST_PARITY: begin
                cnt_d = cnt_next_s;
                if (at_sample_s) begin
                    par_err_d = parity_mismatch(shift_q, bit_val_s);
                end else if (at_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                cnt_d = cnt_next_s;
                if (at_sample_s) begin
                    frm_err_d = frm_err_q | ~bit_val_s;
                    if (bit_idx_q == LAST_STOP_C) begin
                        done_s  = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_STOP;
                    end
                end else if (at_end_s) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        consume_s  = valid_q & rx_if.ready_i;
        data_d     = data_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        ovr_d      = 1'b0;
        if (consume_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        // A completion is only dropped when the held word is neither empty nor being consumed.
        if (done_s && (!valid_q || consume_s)) begin
            valid_d    = 1'b1;
            data_d     = shift_q;
            perr_out_d = par_err_q;
            ferr_out_d = frm_err_d;
        end else if (done_s) begin
            ovr_d = 1'b1;
        end else begin
            ovr_d = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 4'd0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_if.valid_o      = valid_q;
    assign rx_if.data_o       = data_q;
    assign rx_if.parity_err_o = perr_out_q;
    assign rx_if.frame_err_o  = ferr_out_q;
    assign rx_if.overrun_o    = ovr_q;
    assign busy_o             = busy_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance (A) and an even-parity, two-stop-bit instance (B).
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    logic rst_n;
    logic rx_line;
    logic sel;
    logic rx_a, rx_b, busy_a, busy_b;
    int   checks = 0;
    int   failures = 0;
    int   vcyc_a = 0, vcyc_b = 0, ovr_a = 0;
    logic [7:0] cap_a_data, cap_b_data;
    logic cap_a_perr, cap_a_ferr, cap_b_perr, cap_b_ferr;
    int   p, po;

    always #5 clk = ~clk;

    assign rx_a = (sel == 1'b0) ? rx_line : 1'b1;
    assign rx_b = (sel == 1'b1) ? rx_line : 1'b1;

    uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if_b ();

    uart_rx_cfg #(.CLK_DIV_FACTOR(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
        .clk_i(clk), .reset_ni(rst_n), .rx_i(rx_a), .busy_o(busy_a), .rx_if(if_a.master));
    uart_rx_cfg #(.CLK_DIV_FACTOR(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
        .clk_i(clk), .reset_ni(rst_n), .rx_i(rx_b), .busy_o(busy_b), .rx_if(if_b.master));

    // Record every cycle a word is held, and every overrun pulse.
    always @(negedge clk) begin
        if (if_a.valid_o) begin
            vcyc_a     <= vcyc_a + 1;
            cap_a_data <= if_a.data_o;
            cap_a_perr <= if_a.parity_err_o;
            cap_a_ferr <= if_a.frame_err_o;
        end
        if (if_b.valid_o) begin
            vcyc_b     <= vcyc_b + 1;
            cap_b_data <= if_b.data_o;
            cap_b_perr <= if_b.parity_err_o;
            cap_b_ferr <= if_b.frame_err_o;
        end
        if (if_a.overrun_o) ovr_a <= ovr_a + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // bits[0] is the start bit; each bit lasts 16 clocks; glitch pulls cycle 10 of one bit low.
    task automatic send_frame(input logic [15:0] bits, input int nbits, input int glitch);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < 16; c++) begin
                rx_line = ((i == glitch) && (c == 10)) ? 1'b0 : bits[i];
                @(posedge clk);
                #1;
            end
        end
        rx_line = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rx_line = 1'b1;
        sel = 1'b0;
        if_a.ready_i = 1'b1;
        if_b.ready_i = 1'b1;
        tick(3);
        check("rst_valid", 32'(if_a.valid_o), 32'h0);
        check("rst_data", 32'(if_a.data_o), 32'h0);
        check("rst_perr", 32'(if_a.parity_err_o), 32'h0);
        check("rst_ferr", 32'(if_a.frame_err_o), 32'h0);
        check("rst_ovr", 32'(if_a.overrun_o), 32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
        check("rst_b_valid", 32'(if_b.valid_o), 32'h0);
        rst_n = 1'b1;
        tick(4);

        // 8N1 0xA5 with ready high: one-cycle valid pulse
        p = vcyc_a;
        send_frame({6'b0, 1'b1, 8'hA5, 1'b0}, 10, -1);
        tick(4);
        check("a5_pulse", 32'(vcyc_a - p), 32'd1);
        check("a5_data", 32'(cap_a_data), 32'hA5);
        check("a5_perr", 32'(cap_a_perr), 32'h0);
        check("a5_ferr", 32'(cap_a_ferr), 32'h0);
        check("a5_valid_clr", 32'(if_a.valid_o), 32'h0);

        // 4-cycle low glitch in IDLE: false start
        p = vcyc_a;
        rx_line = 1'b0;
        tick(4);
        rx_line = 1'b1;
        check("fs_busy_hi", 32'(busy_a), 32'h1);
        tick(12);
        check("fs_busy_lo", 32'(busy_a), 32'h0);
        check("fs_no_valid", 32'(vcyc_a - p), 32'd0);

        // Overrun: 0x11 then 0x22 with ready low
        if_a.ready_i = 1'b0;
        po = ovr_a;
        send_frame({6'b0, 1'b1, 8'h11, 1'b0}, 10, -1);
        send_frame({6'b0, 1'b1, 8'h22, 1'b0}, 10, -1);
        tick(4);
        check("ovr_valid", 32'(if_a.valid_o), 32'h1);
        check("ovr_data", 32'(if_a.data_o), 32'h11);
        check("ovr_pulses", 32'(ovr_a - po), 32'd1);
        if_a.ready_i = 1'b1;
        check("ovr_valid_hold", 32'(if_a.valid_o), 32'h1);
        tick(1);
        check("ovr_valid_drop", 32'(if_a.valid_o), 32'h0);

        // Even parity, two stop bits on B
        sel = 1'b1;
        p = vcyc_b;
        send_frame({4'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0}, 12, -1);
        tick(4);
        check("p1_pulse", 32'(vcyc_b - p), 32'd1);
        check("p1_data", 32'(cap_b_data), 32'h3C);
        check("p1_perr", 32'(cap_b_perr), 32'h1);
        check("p1_ferr", 32'(cap_b_ferr), 32'h0);
        send_frame({4'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0}, 12, -1);
        tick(4);
        check("p0_data", 32'(cap_b_data), 32'h3C);
        check("p0_perr", 32'(cap_b_perr), 32'h0);
        p = vcyc_b;
        send_frame({4'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 12, -1);
        tick(40);
        check("fe_pulse", 32'(vcyc_b - p), 32'd1);
        check("fe_data", 32'(cap_b_data), 32'h55);
        check("fe_ferr", 32'(cap_b_ferr), 32'h1);
        check("fe_perr", 32'(cap_b_perr), 32'h0);
        sel = 1'b0;
        tick(4);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle low glitch inside data bit 3 is voted out
        p = vcyc_a;
        send_frame({6'b0, 1'b1, 8'hFF, 1'b0}, 10, 4);
        tick(4);
        check("maj_pulse", 32'(vcyc_a - p), 32'd1);
        check("maj_data", 32'(cap_a_data), 32'hFF);
`endif

        // Reset during data bit 3 of 0x0F
        send_frame({6'b0, 1'b1, 8'h0F, 1'b0}, 4, -1);
        rx_line = 1'b1;
        tick(8);
        rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(if_a.valid_o), 32'h0);
        check("mr_data", 32'(if_a.data_o), 32'h0);
        check("mr_perr", 32'(if_a.parity_err_o), 32'h0);
        check("mr_ferr", 32'(if_a.frame_err_o), 32'h0);
        check("mr_ovr", 32'(if_a.overrun_o), 32'h0);
        check("mr_busy", 32'(busy_a), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        p = vcyc_a;
        send_frame({6'b0, 1'b1, 8'hC3, 1'b0}, 10, -1);
        tick(4);
        check("c3_pulse", 32'(vcyc_a - p), 32'd1);
        check("c3_data", 32'(cap_a_data), 32'hC3);
        check("c3_perr", 32'(cap_a_perr), 32'h0);
        check("c3_ferr", 32'(cap_a_ferr), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
